mem_port_arbiter: RTL and testbench

Parametrised N-port arbiter that shares one MemoryController among any number of requesters (instruction fetch, load/store unit, future DMA or prefetch ports). It extends the fixed two-way instruction/data arbitration of the current cache top with these additions:
- configurable port count;
- round-robin or fixed-priority-with-anti-starvation policy;
- per-port write support;
- request capture at grant time.

It sits between the cache/LSU requesters and MemoryController.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_picker.sv | 35 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and memory-size encoding for the N-port memory arbiter.
// The size encoding matches the MemoryController len field.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam logic [2:0] SIZE_BYTE       = 3'b000;
    localparam logic [2:0] SIZE_HALF       = 3'b001;
    localparam logic [2:0] SIZE_WORD       = 3'b010;
    localparam int         SIZE_SIGNED_BIT = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational priority picker with a rotating start position.
// Scans from base upward, wrapping modulo NUM_PORTS; first requester found wins.
module mem_port_arbiter_rr_picker #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     base,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic [IDX_W-1:0]     grant_idx
);

    int   pos;
    logic found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            // base is always below NUM_PORTS, so one subtraction is enough to wrap
            pos = int'(base) + off;
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end
            if (!found && req[pos]) begin
                found         = 1'b1;
                grant_oh[pos] = 1'b1;
                grant_idx     = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MemoryController among NUM_PORTS requesters, round-robin or
// fixed priority with a starvation boost; request fields are latched at grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 7
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [3*NUM_PORTS-1:0]        req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr,
    input  logic [DATA_W*NUM_PORTS-1:0]   req_data,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [DATA_W-1:0]             req_res,
    output logic                          mc_valid,
    output logic                          mc_wr,
    output logic [ADDR_W-1:0]             mc_addr,
    output logic [2:0]                    mc_len,
    output logic [DATA_W-1:0]             mc_data,
    input  logic                          mc_ready,
    input  logic [DATA_W-1:0]             mc_res,
    output logic                          busy,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t            state_reg;
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      rr_ptr_next;
    logic [IDX_W-1:0]      pick_base;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_PORTS-1:0]  win_oh;
    logic [NUM_PORTS-1:0]  starved;
    logic [NUM_PORTS-1:0]  pick_req;
    logic                  arb_fire;
    logic                  complete;

    logic [2:0]            size_arr [NUM_PORTS];
    logic [ADDR_W-1:0]     addr_arr [NUM_PORTS];
    logic [DATA_W-1:0]     data_arr [NUM_PORTS];

    assign arb_fire = rdy_in && (state_reg == ST_IDLE) && (|req_valid);
    // Completion is suppressed while reset is held so an abandoned transfer never pulses.
    assign complete = rst_in && rdy_in && (state_reg == ST_BUSY) && mc_ready;
    assign req_res  = mc_res;

    assign pick_req    = ((FIXED_PRIO != 0) && (|starved)) ? starved : req_valid;
    assign pick_base   = (FIXED_PRIO != 0) ? '0 : rr_ptr_reg;
    assign rr_ptr_next = (int'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + 1'b1;

    mem_port_arbiter_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (pick_req),
        .base      (pick_base),
        .grant_oh  (win_oh),
        .grant_idx (win_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CNT_W-1:0] wait_cnt_reg;

            assign size_arr[gi]  = req_size[gi*3 +: 3];
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = complete && (grant_id == IDX_W'(gi));
            assign starved[gi]   = req_valid[gi] && (wait_cnt_reg == CNT_W'(MAX_WAIT));

            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    wait_cnt_reg <= '0;
                end else if (rdy_in) begin
                    if (!req_valid[gi]) begin
                        wait_cnt_reg <= '0;
                    end else if (arb_fire) begin
                        if (win_oh[gi]) begin
                            wait_cnt_reg <= '0;
                        end else if (wait_cnt_reg != CNT_W'(MAX_WAIT)) begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            grant_id   <= '0;
            mc_valid   <= 1'b0;
            busy       <= 1'b0;
            mc_wr      <= 1'b0;
            mc_addr    <= '0;
            mc_len     <= '0;
            mc_data    <= '0;
        end else if (rdy_in) begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req_valid) begin
                        mc_wr     <= req_wr[win_idx];
                        mc_len    <= size_arr[win_idx];
                        mc_addr   <= addr_arr[win_idx];
                        mc_data   <= data_arr[win_idx];
                        grant_id  <= win_idx;
                        mc_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ST_BUSY;
                        if (FIXED_PRIO == 0) begin
                            rr_ptr_reg <= rr_ptr_next;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mc_ready) begin
                        mc_valid  <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 5-port round-robin arbiter and a 3-port fixed-priority
// arbiter (MAX_WAIT=2) driven by hand-sequenced requesters and MemoryController.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk_in;
    logic rst_n;
    logic rdy;

    logic [4:0]   rr_req_valid, rr_req_wr, rr_req_ready;
    logic [14:0]  rr_req_size;
    logic [159:0] rr_req_addr, rr_req_data;
    logic [31:0]  rr_req_res, rr_mc_addr, rr_mc_data, rr_mc_res;
    logic         rr_mc_valid, rr_mc_wr, rr_mc_ready, rr_busy;
    logic [2:0]   rr_mc_len, rr_grant_id;

    logic [2:0]   fx_req_valid, fx_req_wr, fx_req_ready;
    logic [8:0]   fx_req_size;
    logic [95:0]  fx_req_addr, fx_req_data;
    logic [31:0]  fx_req_res, fx_mc_addr, fx_mc_data, fx_mc_res;
    logic         fx_mc_valid, fx_mc_wr, fx_mc_ready, fx_busy;
    logic [2:0]   fx_mc_len;
    logic [1:0]   fx_grant_id;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .NUM_PORTS(5), .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .MAX_WAIT(7)
    ) u_rr (
        .clk_in(clk_in), .rst_in(rst_n), .rdy_in(rdy),
        .req_valid(rr_req_valid), .req_wr(rr_req_wr), .req_size(rr_req_size),
        .req_addr(rr_req_addr), .req_data(rr_req_data),
        .req_ready(rr_req_ready), .req_res(rr_req_res),
        .mc_valid(rr_mc_valid), .mc_wr(rr_mc_wr), .mc_addr(rr_mc_addr),
        .mc_len(rr_mc_len), .mc_data(rr_mc_data),
        .mc_ready(rr_mc_ready), .mc_res(rr_mc_res),
        .busy(rr_busy), .grant_id(rr_grant_id)
    );

    mem_port_arbiter #(
        .NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .MAX_WAIT(2)
    ) u_fx (
        .clk_in(clk_in), .rst_in(rst_n), .rdy_in(rdy),
        .req_valid(fx_req_valid), .req_wr(fx_req_wr), .req_size(fx_req_size),
        .req_addr(fx_req_addr), .req_data(fx_req_data),
        .req_ready(fx_req_ready), .req_res(fx_req_res),
        .mc_valid(fx_mc_valid), .mc_wr(fx_mc_wr), .mc_addr(fx_mc_addr),
        .mc_len(fx_mc_len), .mc_data(fx_mc_data),
        .mc_ready(fx_mc_ready), .mc_res(fx_mc_res),
        .busy(fx_busy), .grant_id(fx_grant_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_p;
        int fx_seq [6] = '{0, 0, 2, 0, 0, 2};

        rst_n = 1'b0;
        rdy   = 1'b1;
        rr_req_valid = '0; rr_req_wr = '0; rr_req_size = '0; rr_req_data = '0;
        rr_mc_ready  = 1'b0; rr_mc_res = '0;
        fx_req_valid = '0; fx_req_wr = '0; fx_req_size = '0; fx_req_data = '0;
        fx_req_addr  = '0; fx_mc_ready = 1'b0; fx_mc_res = '0;
        for (int i = 0; i < 5; i++) begin
            rr_req_addr[i*32 +: 32] = 32'h1000 + 32'h10 * 32'(i);
        end
        step();
        step();
        rst_n = 1'b1;

        chk("reset_mc_valid", rr_mc_valid, 0);
        chk("reset_busy", rr_busy, 0);
        chk("reset_grant_id", rr_grant_id, 0);
        chk("reset_req_ready", rr_req_ready, 0);
        chk("reset_mc_addr", rr_mc_addr, 0);
        chk("reset_fx_mc_valid", fx_mc_valid, 0);

        // Round-robin, ports 0..2 continuously valid, MC latency 4
        rr_req_valid = 5'b00111;
        for (int t = 0; t < 6; t++) begin
            exp_p = t % 3;
            step();
            chk("rr_grant_mc_valid", rr_mc_valid, 1);
            chk("rr_grant_id", rr_grant_id, 64'(exp_p));
            chk("rr_grant_addr", rr_mc_addr, 64'(32'h1000 + 32'h10 * 32'(exp_p)));
            step();
            step();
            step();
            rr_mc_ready = 1'b1;
            rr_mc_res   = 32'hA000 + 32'(t);
            #1;
            chk("rr_req_ready", rr_req_ready, 64'(5'b00001 << exp_p));
            chk("rr_req_res", rr_req_res, 64'(32'hA000 + 32'(t)));
            step();
            rr_mc_ready = 1'b0;
            chk("rr_turnaround_mc_valid", rr_mc_valid, 0);
            chk("rr_turnaround_busy", rr_busy, 0);
        end

        // Wrap: only port 4, then only port 0
        rr_req_valid = 5'b10000;
        step();
        chk("wrap_grant4", rr_grant_id, 4);
        chk("wrap_rr_ptr", u_rr.rr_ptr_reg, 0);
        rr_mc_ready = 1'b1;
        #1;
        chk("wrap_ready4", rr_req_ready, 5'b10000);
        step();
        rr_mc_ready  = 1'b0;
        rr_req_valid = 5'b00001;
        step();
        step();
        chk("wrap_grant0", rr_grant_id, 0);
        chk("wrap_grant0_valid", rr_mc_valid, 1);
        rr_mc_ready = 1'b1;
        #1;
        chk("wrap_ready0", rr_req_ready, 5'b00001);
        step();
        rr_mc_ready  = 1'b0;
        rr_req_valid = 5'b00000;

        // Write on port 1 with fields scrambled after the grant
        rr_req_valid = 5'b00010;
        rr_req_wr    = 5'b00010;
        rr_req_size[3 +: 3]  = SIZE_WORD;
        rr_req_addr[32 +: 32] = 32'h0000_1234;
        rr_req_data[32 +: 32] = 32'hDEAD_BEEF;
        step();
        chk("wr_grant_id", rr_grant_id, 1);
        chk("wr_mc_wr", rr_mc_wr, 1);
        chk("wr_mc_len", rr_mc_len, 64'(SIZE_WORD));
        chk("wr_mc_addr_g", rr_mc_addr, 32'h0000_1234);
        chk("wr_mc_data_g", rr_mc_data, 32'hDEAD_BEEF);
        rr_req_wr    = 5'b00000;
        rr_req_size[3 +: 3]  = 3'b111;
        rr_req_addr[32 +: 32] = 32'hFFFF_FFF0;
        rr_req_data[32 +: 32] = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wr_hold_addr", rr_mc_addr, 32'h0000_1234);
            chk("wr_hold_data", rr_mc_data, 32'hDEAD_BEEF);
            chk("wr_hold_wr", rr_mc_wr, 1);
        end
        rr_mc_ready = 1'b1;
        #1;
        chk("wr_ready", rr_req_ready, 5'b00010);
        step();
        rr_mc_ready  = 1'b0;
        rr_req_valid = 5'b00000;
        chk("wr_ready_once", rr_req_ready, 0);
        chk("wr_done_mc_valid", rr_mc_valid, 0);

        // rdy_in low for 5 cycles while mc_ready is high
        rr_req_valid = 5'b00100;
        step();
        chk("rdy_grant_id", rr_grant_id, 2);
        chk("rdy_grant_addr", rr_mc_addr, 32'h1020);
        rdy         = 1'b0;
        rr_mc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rdy_low_req_ready", rr_req_ready, 0);
            step();
            chk("rdy_low_mc_valid", rr_mc_valid, 1);
            chk("rdy_low_busy", rr_busy, 1);
        end
        rdy = 1'b1;
        #1;
        chk("rdy_high_req_ready", rr_req_ready, 5'b00100);
        step();
        rr_mc_ready  = 1'b0;
        rr_req_valid = 5'b00000;
        chk("rdy_done_mc_valid", rr_mc_valid, 0);

        // Reset in the middle of a port-1 read at 0x100
        rr_req_addr[32 +: 32] = 32'h0000_0100;
        rr_req_valid = 5'b00010;
        step();
        chk("rst_grant_id", rr_grant_id, 1);
        chk("rst_grant_addr", rr_mc_addr, 32'h100);
        step();
        rst_n       = 1'b0;
        rr_mc_ready = 1'b1;
        #1;
        chk("rst_cycle_req_ready", rr_req_ready, 0);
        step();
        chk("rst_mc_valid", rr_mc_valid, 0);
        chk("rst_busy", rr_busy, 0);
        chk("rst_grant_id_zero", rr_grant_id, 0);
        chk("rst_mc_addr", rr_mc_addr, 0);
        chk("rst_rr_ptr", u_rr.rr_ptr_reg, 0);
        chk("rst_after_req_ready", rr_req_ready, 0);
        rst_n        = 1'b1;
        rr_req_valid = 5'b00000;
        step();
        chk("rst_idle_mc_ready_ignored", rr_req_ready, 0);
        rr_mc_ready = 1'b0;

        // Fixed priority with boost: ports 0 and 2 always valid
        fx_req_addr[0 +: 32]  = 32'h2000;
        fx_req_addr[64 +: 32] = 32'h2200;
        fx_req_valid = 3'b101;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("fx_grant_id", fx_grant_id, 64'(fx_seq[t]));
            chk("fx_grant_addr", fx_mc_addr, 64'(fx_seq[t] == 0 ? 32'h2000 : 32'h2200));
            fx_mc_ready = 1'b1;
            fx_mc_res   = 32'hB000 + 32'(t);
            #1;
            chk("fx_req_ready", fx_req_ready, 64'(3'b001 << fx_seq[t]));
            chk("fx_req_res", fx_req_res, 64'(32'hB000 + 32'(t)));
            step();
            fx_mc_ready = 1'b0;
            chk("fx_turnaround", fx_mc_valid, 0);
        end
        fx_req_valid = 3'b000;
        chk("fx_idle_wr", fx_mc_wr, 0);
        chk("fx_busy_low", fx_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
